// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC access arbiter.
// State encoding, trigger polarity and default register widths.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    COMPLETE
  } arb_state_t;

  localparam logic TRIG_ACTIVE = 1'b0;

  localparam int RTC_ADDR_W = 3;
  localparam int RTC_DATA_W = 8;

endpackage

// File: rtl/rtc_access_arbiter_if.sv
// Requester and RTC register-file signals seen by the arbiter.
// The master side drives requests and read data; the slave is the arbiter.
interface rtc_access_arbiter_if
  import rtc_pkg::*;
#(
  parameter int ADDR_W = RTC_ADDR_W,
  parameter int DATA_W = RTC_DATA_W
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rtc_addr;
  logic [DATA_W-1:0] rtc_wdata;
  logic [DATA_W-1:0] rtc_rdata;
  logic              write_trig;
  logic              read_trig;
  logic              busy;

  modport master (
    output req, we, addr0, addr1,
    output wdata0, wdata1, rtc_rdata,
    input  gnt, done, rdata,
    input  rtc_addr, rtc_wdata,
    input  write_trig, read_trig, busy
  );

  modport slave (
    input  req, we, addr0, addr1,
    input  wdata0, wdata1, rtc_rdata,
    output gnt, done, rdata,
    output rtc_addr, rtc_wdata,
    output write_trig, read_trig, busy
  );

endinterface

// File: rtl/rtc_rr_pick.sv
// Two-way round-robin picker: on contention the port that
// did not win last time is chosen.
module rtc_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       valid
);

  always_comb begin
    win   = 2'b00;
    valid = |req;
    unique case (1'b1)
      (req == 2'b11): win = last ? 2'b01 : 2'b10;
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

endmodule

// File: rtl/rtc_access_arbiter.sv
// Round-robin arbiter sharing the RTC register file between the host
// and the alarm/display unit; generates the read/write trigger strobes.
module rtc_access_arbiter
  import rtc_pkg::*;
#(
  parameter int ADDR_W  = RTC_ADDR_W,
  parameter int DATA_W  = RTC_DATA_W,
  parameter int ACC_CYC = 2
) (
  input logic                 clk,
  input logic                 rstn,
  rtc_access_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

  arb_state_t state;
  logic [3:0] cnt;
  logic       last;
  logic       sel;
  logic       we_q;
  logic [1:0] win;
  logic       win_vld;

  rtc_rr_pick u_pick (
    .req   (bus.req),
    .last  (last),
    .win   (win),
    .valid (win_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      last           <= 1'b1;
      sel            <= 1'b0;
      we_q           <= 1'b0;
      bus.gnt        <= 2'b00;
      bus.done       <= 2'b00;
      bus.busy       <= 1'b0;
      bus.write_trig <= ~TRIG_ACTIVE;
      bus.read_trig  <= ~TRIG_ACTIVE;
      bus.rtc_addr   <= '0;
      bus.rtc_wdata  <= '0;
      bus.rdata      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            bus.gnt  <= win;
            sel      <= win[1];
            bus.busy <= 1'b1;
            if (win[1]) begin
              we_q          <= bus.we[1];
              bus.rtc_addr  <= bus.addr1;
              bus.rtc_wdata <= bus.wdata1;
            end else begin
              we_q          <= bus.we[0];
              bus.rtc_addr  <= bus.addr0;
              bus.rtc_wdata <= bus.wdata0;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (we_q) bus.write_trig <= TRIG_ACTIVE;
          else      bus.read_trig  <= TRIG_ACTIVE;
          cnt   <= '0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            bus.write_trig <= ~TRIG_ACTIVE;
            bus.read_trig  <= ~TRIG_ACTIVE;
            if (!we_q) bus.rdata <= bus.rtc_rdata;
            bus.done[sel] <= 1'b1;
            state         <= COMPLETE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        COMPLETE: begin
          bus.done <= 2'b00;
          bus.gnt  <= 2'b00;
          bus.busy <= 1'b0;
          last     <= sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_arbiter.sv
// Directed bench for rtc_access_arbiter: ACC_CYC=2 and ACC_CYC=1 builds.
// Expected values are hand-computed from the cycle-level timing.
module tb_rtc_access_arbiter;
  import rtc_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int checks = 0;
  int errors = 0;

  rtc_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) a_if ();
  rtc_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) b_if ();

  rtc_access_arbiter #(
    .ADDR_W(3), .DATA_W(8), .ACC_CYC(2)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (a_if.slave)
  );

  rtc_access_arbiter #(
    .ADDR_W(3), .DATA_W(8), .ACC_CYC(1)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    while (a_if.busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, a_if.busy, 1'b0);
  endtask

  int n, rlow, wlow, seen, grants, idle, overlap;
  logic [1:0] prev_g;
  logic [1:0] order [4];

  initial begin
    rstn = 1'b0;
    a_if.req = 0; a_if.we = 0;
    a_if.addr0 = 0; a_if.addr1 = 0;
    a_if.wdata0 = 0; a_if.wdata1 = 0;
    a_if.rtc_rdata = 0;
    b_if.req = 0; b_if.we = 0;
    b_if.addr0 = 0; b_if.addr1 = 0;
    b_if.wdata0 = 0; b_if.wdata1 = 0;
    b_if.rtc_rdata = 0;
    repeat (2) step();

    chk("rst_gnt", a_if.gnt, 2'b00);
    chk("rst_done", a_if.done, 2'b00);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_wtrig", a_if.write_trig, 1'b1);
    chk("rst_rtrig", a_if.read_trig, 1'b1);
    chk("rst_addr", a_if.rtc_addr, 3'h0);
    chk("rst_wdata", a_if.rtc_wdata, 8'h00);
    chk("rst_rdata", a_if.rdata, 8'h00);
    #3 rstn = 1'b1;

    // single write from port 0
    a_if.req = 2'b01; a_if.we = 2'b01;
    a_if.addr0 = 3'h2; a_if.wdata0 = 8'h59;
    step();
    chk("wr_gnt", a_if.gnt, 2'b01);
    chk("wr_busy", a_if.busy, 1'b1);
    chk("wr_setup_wt", a_if.write_trig, 1'b1);
    step();
    chk("wr_s1_wt", a_if.write_trig, 1'b0);
    chk("wr_s1_rt", a_if.read_trig, 1'b1);
    chk("wr_s1_addr", a_if.rtc_addr, 3'h2);
    chk("wr_s1_data", a_if.rtc_wdata, 8'h59);
    step();
    chk("wr_s2_wt", a_if.write_trig, 1'b0);
    chk("wr_s2_done", a_if.done, 2'b00);
    step();
    chk("wr_end_wt", a_if.write_trig, 1'b1);
    chk("wr_done", a_if.done, 2'b01);
    chk("wr_done_gnt", a_if.gnt, 2'b01);
    a_if.req = 2'b00;
    step();
    chk("wr_cpl_done", a_if.done, 2'b00);
    chk("wr_cpl_gnt", a_if.gnt, 2'b00);
    chk("wr_cpl_busy", a_if.busy, 1'b0);

    // single read from port 1
    a_if.req = 2'b10; a_if.we = 2'b00;
    a_if.addr1 = 3'h1; a_if.rtc_rdata = 8'h23;
    n = 0; rlow = 0; wlow = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      n++;
      if (!a_if.read_trig) rlow++;
      if (!a_if.write_trig) wlow++;
      if (a_if.done[1]) seen = 1;
    end
    chk("rd_done_seen", seen, 1);
    chk("rd_edges", n, 4);
    chk("rd_rlow", rlow, 2);
    chk("rd_wlow", wlow, 0);
    chk("rd_rdata", a_if.rdata, 8'h23);
    chk("rd_done", a_if.done, 2'b10);
    chk("rd_addr", a_if.rtc_addr, 3'h1);
    a_if.req = 2'b00; a_if.rtc_rdata = 8'h55;
    step();
    chk("rd_hold", a_if.rdata, 8'h23);
    chk("rd_done_clr", a_if.done, 2'b00);

    // contention straight after reset
    rstn = 1'b0;
    #2 rstn = 1'b1;
    a_if.req = 2'b11; a_if.we = 2'b11;
    prev_g = 2'b00; grants = 0; idle = 0; overlap = 0;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      step();
      if (a_if.gnt == 2'b11) overlap++;
      if (a_if.gnt != 2'b00 && prev_g == 2'b00) begin
        order[grants] = a_if.gnt;
        if (grants > 0) chk("cont_gap", idle, 1);
        grants++;
        idle = 0;
      end else if (a_if.gnt == 2'b00) begin
        idle++;
      end
      prev_g = a_if.gnt;
    end
    a_if.req = 2'b00;
    chk("cont_grants", grants, 4);
    chk("cont_g0", order[0], 2'b01);
    chk("cont_g1", order[1], 2'b10);
    chk("cont_g2", order[2], 2'b01);
    chk("cont_g3", order[3], 2'b10);
    chk("cont_overlap", overlap, 0);
    wait_idle_a("cont_idle");

    // drop req and change address mid-strobe
    a_if.req = 2'b01; a_if.we = 2'b01;
    a_if.addr0 = 3'h5; a_if.wdata0 = 8'hAA;
    step();
    step();
    a_if.req = 2'b00; a_if.addr0 = 3'h7;
    a_if.wdata0 = 8'h11; a_if.we = 2'b00;
    step();
    chk("drop_wt", a_if.write_trig, 1'b0);
    chk("drop_addr", a_if.rtc_addr, 3'h5);
    chk("drop_data", a_if.rtc_wdata, 8'hAA);
    step();
    chk("drop_done", a_if.done, 2'b01);
    chk("drop_rt", a_if.read_trig, 1'b1);
    step();
    chk("drop_idle", a_if.busy, 1'b0);

    // asynchronous reset while write_trig is low
    a_if.req = 2'b01; a_if.we = 2'b01;
    step();
    step();
    chk("arst_pre_wt", a_if.write_trig, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_wt", a_if.write_trig, 1'b1);
    chk("arst_gnt", a_if.gnt, 2'b00);
    chk("arst_busy", a_if.busy, 1'b0);
    chk("arst_done", a_if.done, 2'b00);
    a_if.req = 2'b11;
    #3 rstn = 1'b1;
    step();
    chk("arst_first", a_if.gnt, 2'b01);
    a_if.req = 2'b00;
    wait_idle_a("arst_idle");

    // ACC_CYC=1 build: write then read
    b_if.req = 2'b01; b_if.we = 2'b01;
    b_if.addr0 = 3'h4; b_if.wdata0 = 8'h3C;
    n = 0; wlow = 0; rlow = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      n++;
      if (!b_if.write_trig) wlow++;
      if (!b_if.read_trig) rlow++;
      if (b_if.done[0]) seen = 1;
    end
    chk("b_wr_seen", seen, 1);
    chk("b_wr_edges", n, 3);
    chk("b_wr_wlow", wlow, 1);
    chk("b_wr_rlow", rlow, 0);
    b_if.req = 2'b00;
    step();
    chk("b_wr_gnt_clr", b_if.gnt, 2'b00);

    b_if.req = 2'b10; b_if.we = 2'b00;
    b_if.addr1 = 3'h6; b_if.rtc_rdata = 8'h9A;
    n = 0; wlow = 0; rlow = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      n++;
      if (!b_if.write_trig) wlow++;
      if (!b_if.read_trig) rlow++;
      if (b_if.done[1]) seen = 1;
    end
    chk("b_rd_seen", seen, 1);
    chk("b_rd_edges", n, 3);
    chk("b_rd_rlow", rlow, 1);
    chk("b_rd_rdata", b_if.rdata, 8'h9A);
    b_if.req = 2'b00;
    step();
    chk("b_rd_busy", b_if.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_access_arbiter.md
Name: rtc_access_arbiter

Overview:
- Shares the RTC time/alarm register file between two requesters: port 0 is the host, port 1 is the alarm/display unit.
- Round-robin arbitration with a req/gnt/done handshake.
- Sequences each access as address/data setup, then an active-low write_trig or read_trig strobe held for ACC_CYC cycles, then a one-cycle done pulse.
- Sits between the requesters and the RTC register block, replacing direct trigger generation.

Parameters:
- ADDR_W, 3, RTC register address width.
- DATA_W, 8, RTC register data width.
- ACC_CYC, 2, cycles the trigger strobe is held low (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- req  in  2  per-port access request; held high until done.
- we  in  2  per-port direction: 1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  ADDR_W each  per-port register address.
- wdata0 / wdata1  in  DATA_W each  per-port write data.
- gnt  out  2  one-hot grant, high for the whole transaction.
- done  out  2  one-cycle completion pulse to the granted port.
- rdata  out  DATA_W  read result; valid while done is high, held until the next read completes.
- rtc_addr  out  ADDR_W  address to the RTC register file.
- rtc_wdata  out  DATA_W  write data to the RTC register file.
- rtc_rdata  in  DATA_W  read data from the RTC register file.
- write_trig  out  1  active-low write strobe.
- read_trig  out  1  active-low read strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; gnt = 0; done = 0; busy = 0.
  - write_trig = 1; read_trig = 1; rtc_addr = 0; rtc_wdata = 0; rdata = 0.
  - Last-winner pointer = 1, so port 0 wins the first contended arbitration.
- States: IDLE, SETUP, STROBE, COMPLETE. All outputs are registered.
- IDLE:
  - req == 0: stay in IDLE.
  - Exactly one req bit set: that port wins regardless of the pointer.
  - Both bits set: the port that is not the last winner wins.
  - On the winning edge: gnt[w] <= 1; latch we[w], addr_w and wdata_w into rtc_addr/rtc_wdata; busy <= 1; next state SETUP.
- SETUP: exactly one cycle for address/data setup. On exit, drive write_trig <= 0 if the latched we = 1, else read_trig <= 0. Clear the cycle counter; next state STROBE.
- STROBE:
  - Strobe is held low for exactly ACC_CYC cycles.
  - On the final edge: strobe <= 1; on a read, rdata <= rtc_rdata; done[w] <= 1; next state COMPLETE.
- COMPLETE: exactly one cycle. done <= 0; gnt <= 0; busy <= 0; pointer <= w; next state IDLE.
- Latency: with req sampled at edge N, done is high in the cycle after edge N+ACC_CYC+1. A transaction occupies ACC_CYC+3 cycles end to end.
- rtc_addr and rtc_wdata stay stable from SETUP through the end of STROBE. The two triggers are never low simultaneously.
- If req drops mid-transaction, it is ignored; the access completes and done still pulses.
- A requester that keeps req high after done issues a new request. If the other port is also requesting, the other port wins next.
- Changes to we, addr or wdata after grant have no effect on the current transaction.
- Reset asserted mid-operation: immediate return to reset values. The strobe goes high asynchronously and no done is issued.
- The pointer updates only in COMPLETE.

Decomposition:
- rtc_pkg holds:
  - the state enum arb_state_t (IDLE, SETUP, STROBE, COMPLETE);
  - the constant TRIG_ACTIVE = 1'b0;
  - the default widths RTC_ADDR_W = 3 and RTC_DATA_W = 8.
- Sub-module rtc_rr_pick: combinational two-way round-robin picker. Inputs: req[1:0] and the last winner. Outputs: a one-hot winner and a valid flag.

Test Plan:
- Single write: port 0 requests with we=1, addr0=3'h2, wdata0=8'h59. Expect gnt=2'b01; rtc_addr=2 and rtc_wdata=8'h59 during the strobe; write_trig low for exactly 2 cycles; done[0] high one cycle later; read_trig stays 1 throughout.
- Single read: port 1 requests with we=0, addr1=3'h1, rtc_rdata=8'h23. Expect read_trig low for 2 cycles, rdata=8'h23 while done[1] is high, and total latency of 5 cycles.
- Contention: both ports request and hold req after reset. Expect grant order port 0, port 1, port 0, port 1 with no overlapping gnt. The gap between one done and the next grant is exactly 1 cycle.
- Drop/change during a transaction: port 0 deasserts req and changes addr0 while the strobe is active. Expect the strobe held with the original address and done[0] still pulsed.
- Reset mid-strobe: rstn goes low while write_trig=0. Expect write_trig=1, gnt=0 and busy=0 immediately without waiting for a clock edge. After release, port 0 wins a contended request.
- ACC_CYC=1 build: expect each trigger low for exactly 1 cycle and a 4-cycle transaction.
